dmem_arbiter: RTL



---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_arbiter_rr_pick2.sv | 66 ++++++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: owner encoding, the memory
// request bundle and the debug view of the arbiter state.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 16;
    localparam int LOCK_DBG_W  = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_OWN  = 2'd1,
        HOST_OWN = 2'd2
    } owner_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        owner_e                owner;
        logic                  last_host;
        logic [LOCK_DBG_W-1:0] lock_cnt;
    } dbg_t;

    function automatic mem_req_t make_req(input logic                   we,
                                          input logic [DMEM_ADDR_W-1:0] addr,
                                          input logic [DMEM_DATA_W-1:0] wdata);
        mem_req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-requester round-robin picker (bit 0 = CPU, bit 1 = host) with a
// bounded lock override that lets the host keep the memory for a burst.
module rr_pick2
    import dmem_pkg::*;
#(
    parameter int MAX_LOCK = 4,
    parameter int LCW      = $clog2(MAX_LOCK + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     req_i,
    input  logic           lock_i,
    input  logic           host_own_i,
    output logic [1:0]     gnt_o,
    output logic           last_host_o,
    output logic [LCW-1:0] lock_cnt_o
);

    logic           last_host_q, last_host_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           lock_win;

    always_comb begin
        lock_win = host_own_i && lock_i && (lock_cnt_q < LCW'(MAX_LOCK));
        gnt_o    = 2'b00;
        if (!reset) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (lock_win || !last_host_q) ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    // A burst run ends on any CPU grant or as soon as the host drops lock.
    always_comb begin
        last_host_d = last_host_q;
        if (gnt_o[0]) begin
            last_host_d = 1'b0;
        end else if (gnt_o[1]) begin
            last_host_d = 1'b1;
        end

        lock_cnt_d = lock_cnt_q;
        if (gnt_o[0] || !lock_i) begin
            lock_cnt_d = '0;
        end else if (gnt_o[1] && (lock_cnt_q != LCW'(MAX_LOCK))) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_host_q <= 1'b1;
            lock_cnt_q  <= '0;
        end else begin
            last_host_q <= last_host_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end

    assign last_host_o = last_host_q;
    assign lock_cnt_o  = lock_cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU control unit and the
// host/debug port; one access per cycle, read data routed back by owner tag.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_LOCK = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic              host_lock,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt,
    output dbg_t              dbg_o
);

    localparam int LCW = $clog2(MAX_LOCK + 1);

    // Handshake: req is the valid, gnt is the ready. A requester holds req and
    // its addr/we/wdata stable until it sees gnt=1; the access happens at that
    // rising edge, and a read returns exactly one cycle later on rvalid.

    owner_e            owner_q;
    logic              rd_cpu_q, rd_host_q;
    logic [DATA_W-1:0] cpu_hold_q, host_hold_q;
    logic [CNT_W-1:0]  conflict_q, conflict_d;
    logic [1:0]        gnt;
    logic              last_host;
    logic [LCW-1:0]    lock_cnt;
    mem_req_t          cpu_r, host_r, win_r;

    rr_pick2 #(
        .MAX_LOCK (MAX_LOCK),
        .LCW      (LCW)
    ) u_pick (
        .clk         (clk),
        .reset       (reset),
        .req_i       ({host_req, cpu_req}),
        .lock_i      (host_lock),
        .host_own_i  (owner_q == HOST_OWN),
        .gnt_o       (gnt),
        .last_host_o (last_host),
        .lock_cnt_o  (lock_cnt)
    );

    assign cpu_gnt  = gnt[0];
    assign host_gnt = gnt[1];

    // mem_req_t is sized by the package defaults; instantiate with matching widths.
    always_comb begin
        cpu_r  = make_req(cpu_we, cpu_addr, cpu_wdata);
        host_r = make_req(host_we, host_addr, host_wdata);
        win_r  = '0;
        if (gnt[0]) begin
            win_r = cpu_r;
        end else if (gnt[1]) begin
            win_r = host_r;
        end
    end

    assign mem_addr  = win_r.addr;
    assign mem_wdata = win_r.wdata;
    assign mem_wr    = win_r.we;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q   <= IDLE;
            rd_cpu_q  <= 1'b0;
            rd_host_q <= 1'b0;
        end else begin
            rd_cpu_q  <= cpu_gnt & ~cpu_we;
            rd_host_q <= host_gnt & ~host_we;
            if (cpu_gnt) begin
                owner_q <= CPU_OWN;
            end else if (host_gnt) begin
                owner_q <= HOST_OWN;
            end else begin
                owner_q <= IDLE;
            end
        end
    end

    // A read landing in a reset cycle is dropped rather than returned.
    assign cpu_rvalid  = rd_cpu_q & ~reset;
    assign host_rvalid = rd_host_q & ~reset;
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_hold_q;
    assign host_rdata  = host_rvalid ? mem_rdata : host_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_hold_q  <= '0;
            host_hold_q <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_hold_q <= mem_rdata;
            end
            if (host_rvalid) begin
                host_hold_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (cpu_req && host_req && (conflict_q != '1)) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;

    assign dbg_o = '{owner: owner_q, last_host: last_host,
                     lock_cnt: LOCK_DBG_W'(lock_cnt)};

endmodule
